teclado_cajero: RTL and testbench
=================================

// Module: teclado_cajero
// PURPOSE
//  Keypad/card-slot front end driving the cajero controller's input side.
//  Converts single-cycle key events into the cajero protocol:
//  - TARJETA_RECIBIDA level and TIPO_TRNANS selection.
//  - DIGITO/DIGITO_STB PIN strobes.
//  - Decimal-accumulated MONTO with MONTO_STB.
//  Tracks cajero result outputs to sequence the session phases.
// PARAMETERS
//  N_PIN        4   PIN digits sent before waiting for the verdict
//  MAX_DIGITOS  9   max amount digits accepted (999_999_999 fits 32 bits)
//  PIN_TIMEOUT  4   cycles after last PIN strobe with no PIN_INCORRECTO/BLOQUEO => PIN accepted
// PORTS
//  clk                   in   1   system clock, rising edge
//  rst                   in   1   synchronous, active-high reset
//  TARJETA_IN            in   1   card-present level from slot sensor
//  KEY_VALID             in   1   one-cycle key event (debounced upstream)
//  KEY_CODE              in   4   0-9 digit, A deposit, B withdrawal, C cancel, E enter; others ignored
//  PIN_INCORRECTO        in   1   from cajero
//  BLOQUEO               in   1   from cajero
//  ENTREGAR_DINERO       in   1   from cajero
//  FONDOS_INSUFICIENTES  in   1   from cajero
//  BALANCE_ACTUALIZADO   in   1   from cajero
//  TARJETA_RECIBIDA      out  1   to cajero: high for whole session
//  TIPO_TRNANS           out  1   to cajero: 0 deposit, 1 withdrawal
//  DIGITO_STB            out  1   to cajero: one-cycle PIN digit strobe
//  DIGITO                out  4   to cajero: PIN digit, valid with DIGITO_STB
//  MONTO_STB             out  1   to cajero: one-cycle amount strobe
//  MONTO                 out  32  to cajero: binary amount
//  ESTADO                out  3   current state encoding (debug)
// BEHAVIOUR
//  Reset / all outputs
//  - All outputs registered; reset drives all to 0, state IDLE.
//  States and transitions
//  - IDLE(0): TARJETA_IN=1 -> SELECT, TARJETA_RECIBIDA<=1 next cycle.
//  - SELECT(1): key A -> TIPO_TRNANS<=0, PIN; key B -> TIPO_TRNANS<=1, PIN.
//  - PIN(2): digit key at cycle n -> DIGITO=code, DIGITO_STB=1 at n+1 only.
//    After the N_PIN-th digit -> WAIT_PIN. Non-digits ignored.
//  - WAIT_PIN(3):
//    - PIN_INCORRECTO -> PIN, digit count cleared.
//    - BLOQUEO -> BLOCKED.
//    - PIN_TIMEOUT cycles without either -> AMOUNT, MONTO cleared.
//  - AMOUNT(4):
//    - Digit d: MONTO<=MONTO*10+d while count<MAX_DIGITOS; extra digits dropped.
//    - E with count>=1: MONTO_STB=1 for one cycle -> WAIT_RES.
//    - E with count=0: ignored.
//  - WAIT_RES(5): ENTREGAR_DINERO | FONDOS_INSUFICIENTES | BALANCE_ACTUALIZADO -> EJECT.
//  - EJECT(6), BLOCKED(7): keys ignored; wait for TARJETA_IN=0.
//  Global rules
//  - Key C in SELECT/PIN/WAIT_PIN/AMOUNT/WAIT_RES -> EJECT.
//  - TARJETA_IN=0 in any state -> IDLE next cycle; all outputs cleared. Card removal wins over any same-cycle key or cajero input.
//  - Keys arriving in WAIT_PIN/WAIT_RES/EJECT/BLOCKED/IDLE are dropped, not queued.
//  - MONTO holds its value from MONTO_STB until return to IDLE.
//  - TIPO_TRNANS holds from selection until return to IDLE.
//  - DIGITO holds its last value between strobes.
//  - rst asserted mid-session -> immediate IDLE, no pending strobes emitted.
// TESTING
//  - Card in, B, digits 1,2,3,4 -> TIPO_TRNANS=1; four DIGITO_STB pulses with DIGITO=1,2,3,4, each 1 cycle after its key.
//  - After PIN, PIN_INCORRECTO pulse -> back to PIN (ESTADO=2); next 4 digits strobed again; BLOQUEO -> ESTADO=7, keys ignored until card out.
//  - PIN accepted by timeout, keys 5,0,0,E -> MONTO=500, one MONTO_STB; ENTREGAR_DINERO -> ESTADO=6.
//  - Ten digit keys 9 then E -> MONTO=999_999_999; E with no digits -> no MONTO_STB.
//  - Key C during AMOUNT -> EJECT, no MONTO_STB; card removed -> IDLE, all outputs 0.
//  - Card removed same cycle as digit key in PIN -> no DIGITO_STB, IDLE next cycle; rst mid-AMOUNT clears MONTO.

Source files
------------

// File: rtl/teclado_cajero.sv
// rtl/teclado_cajero.sv - keypad/card-slot front end that turns key events into cajero PIN/amount strobes
// Card removal and reset dominate; every output is a register so the cajero never sees combinational glitches.
module teclado_cajero #(
  parameter int N_PIN       = 4,
  parameter int MAX_DIGITOS = 9,
  parameter int PIN_TIMEOUT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tarjeta_in_i,
  input  logic        key_valid_i,
  input  logic [3:0]  key_code_i,
  input  logic        pin_incorrecto_i,
  input  logic        bloqueo_i,
  input  logic        entregar_dinero_i,
  input  logic        fondos_insuficientes_i,
  input  logic        balance_actualizado_i,
  output logic        tarjeta_recibida_o,
  output logic        tipo_trnans_o,
  output logic        digito_stb_o,
  output logic [3:0]  digito_o,
  output logic        monto_stb_o,
  output logic [31:0] monto_o,
  output logic [2:0]  estado_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    PIN      = 3'd2,
    WAIT_PIN = 3'd3,
    AMOUNT   = 3'd4,
    WAIT_RES = 3'd5,
    EJECT    = 3'd6,
    BLOCKED  = 3'd7
  } state_t;

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_E = 4'hE;

  localparam logic [7:0] PIN_LAST     = 8'(N_PIN - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(PIN_TIMEOUT - 1);
  localparam logic [7:0] MAX_CNT      = 8'(MAX_DIGITOS);

  state_t      state_q, state_d;
  logic        recib_q, recib_d;
  logic        tipo_q, tipo_d;
  logic        digito_stb_q, digito_stb_d;
  logic [3:0]  digito_q, digito_d;
  logic        monto_stb_q, monto_stb_d;
  logic [31:0] monto_q, monto_d;
  logic [7:0]  pin_cnt_q, pin_cnt_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  amt_cnt_q, amt_cnt_d;

  logic key_digit, key_a, key_b, key_c, key_e, resultado;

  assign key_digit = key_valid_i && (key_code_i <= 4'd9);
  assign key_a     = key_valid_i && (key_code_i == KEY_A);
  assign key_b     = key_valid_i && (key_code_i == KEY_B);
  assign key_c     = key_valid_i && (key_code_i == KEY_C);
  assign key_e     = key_valid_i && (key_code_i == KEY_E);
  assign resultado = entregar_dinero_i || fondos_insuficientes_i || balance_actualizado_i;

  always_comb begin
    state_d      = state_q;
    recib_d      = recib_q;
    tipo_d       = tipo_q;
    digito_stb_d = 1'b0;
    digito_d     = digito_q;
    monto_stb_d  = 1'b0;
    monto_d      = monto_q;
    pin_cnt_d    = pin_cnt_q;
    timer_d      = timer_q;
    amt_cnt_d    = amt_cnt_q;

    if (!tarjeta_in_i) begin
      state_d   = IDLE;
      recib_d   = 1'b0;
      tipo_d    = 1'b0;
      digito_d  = 4'd0;
      monto_d   = 32'd0;
      pin_cnt_d = 8'd0;
      timer_d   = 8'd0;
      amt_cnt_d = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SELECT;
          recib_d = 1'b1;
        end
        SELECT: begin
          if (key_a || key_b) begin
            tipo_d    = key_b;
            pin_cnt_d = 8'd0;
            state_d   = PIN;
          end else if (key_c) begin
            state_d = EJECT;
          end
        end
        PIN: begin
          if (key_c) begin
            state_d = EJECT;
          end else if (key_digit) begin
            digito_d     = key_code_i;
            digito_stb_d = 1'b1;
            if (pin_cnt_q == PIN_LAST) begin
              timer_d = 8'd0;
              state_d = WAIT_PIN;
            end else begin
              pin_cnt_d = pin_cnt_q + 8'd1;
            end
          end
        end
        // Silence from the cajero for PIN_TIMEOUT cycles means the PIN was accepted.
        WAIT_PIN: begin
          if (bloqueo_i) begin
            state_d = BLOCKED;
          end else if (pin_incorrecto_i) begin
            pin_cnt_d = 8'd0;
            state_d   = PIN;
          end else if (key_c) begin
            state_d = EJECT;
          end else if (timer_q == TIMEOUT_LAST) begin
            monto_d   = 32'd0;
            amt_cnt_d = 8'd0;
            state_d   = AMOUNT;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        AMOUNT: begin
          if (key_c) begin
            state_d = EJECT;
          end else if (key_digit) begin
            if (amt_cnt_q < MAX_CNT) begin
              monto_d   = monto_q * 32'd10 + {28'd0, key_code_i};
              amt_cnt_d = amt_cnt_q + 8'd1;
            end
          end else if (key_e && (amt_cnt_q != 8'd0)) begin
            monto_stb_d = 1'b1;
            state_d     = WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (resultado || key_c) state_d = EJECT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      recib_q      <= 1'b0;
      tipo_q       <= 1'b0;
      digito_stb_q <= 1'b0;
      digito_q     <= 4'd0;
      monto_stb_q  <= 1'b0;
      monto_q      <= 32'd0;
      pin_cnt_q    <= 8'd0;
      timer_q      <= 8'd0;
      amt_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      recib_q      <= recib_d;
      tipo_q       <= tipo_d;
      digito_stb_q <= digito_stb_d;
      digito_q     <= digito_d;
      monto_stb_q  <= monto_stb_d;
      monto_q      <= monto_d;
      pin_cnt_q    <= pin_cnt_d;
      timer_q      <= timer_d;
      amt_cnt_q    <= amt_cnt_d;
    end
  end

  assign tarjeta_recibida_o = recib_q;
  assign tipo_trnans_o      = tipo_q;
  assign digito_stb_o       = digito_stb_q;
  assign digito_o           = digito_q;
  assign monto_stb_o        = monto_stb_q;
  assign monto_o            = monto_q;
  assign estado_o           = state_q;

endmodule

// File: tb/tb_teclado_cajero.sv
// tb/tb_teclado_cajero.sv - directed sessions plus random traffic against a session-level reference model
module tb_teclado_cajero;

  localparam int N_PIN       = 4;
  localparam int MAX_DIGITOS = 9;
  localparam int PIN_TIMEOUT = 4;

  localparam int P_IDLE = 0, P_SELECT = 1, P_PIN = 2, P_WAIT_PIN = 3;
  localparam int P_AMOUNT = 4, P_WAIT_RES = 5, P_EJECT = 6, P_BLOCKED = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tarjeta_in = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        pin_incorrecto = 1'b0;
  logic        bloqueo = 1'b0;
  logic        entregar_dinero = 1'b0;
  logic        fondos_insuficientes = 1'b0;
  logic        balance_actualizado = 1'b0;
  logic        tarjeta_recibida, tipo_trnans, digito_stb, monto_stb;
  logic [3:0]  digito;
  logic [31:0] monto;
  logic [2:0]  estado;

  teclado_cajero #(.N_PIN(N_PIN), .MAX_DIGITOS(MAX_DIGITOS), .PIN_TIMEOUT(PIN_TIMEOUT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .tarjeta_in_i(tarjeta_in),
    .key_valid_i(key_valid),
    .key_code_i(key_code),
    .pin_incorrecto_i(pin_incorrecto),
    .bloqueo_i(bloqueo),
    .entregar_dinero_i(entregar_dinero),
    .fondos_insuficientes_i(fondos_insuficientes),
    .balance_actualizado_i(balance_actualizado),
    .tarjeta_recibida_o(tarjeta_recibida),
    .tipo_trnans_o(tipo_trnans),
    .digito_stb_o(digito_stb),
    .digito_o(digito),
    .monto_stb_o(monto_stb),
    .monto_o(monto),
    .estado_o(estado)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Session-level reference: digits collected in queues, amount recomputed from them.
  int       m_ph = P_IDLE;
  bit       m_recib = 0, m_tipo = 0, m_dstb = 0, m_mstb = 0;
  int       m_dig = 0;
  int       m_since = 0;
  int       pin_q[$];
  int       amt_q[$];

  function automatic longint amt_val();
    longint v = 0;
    foreach (amt_q[i]) v = v * 10 + amt_q[i];
    return v;
  endfunction

  task automatic session_clear();
    m_ph = P_IDLE; m_recib = 0; m_tipo = 0; m_dig = 0; m_since = 0;
    pin_q.delete(); amt_q.delete();
  endtask

  task automatic model_adv(input bit r, input bit card, input bit kv, input int kc,
                           input bit pi, input bit bl, input bit res);
    bit is_dig, k_a, k_b, k_c, k_e;
    is_dig = kv && kc <= 9;
    k_a = kv && kc == 10; k_b = kv && kc == 11; k_c = kv && kc == 12; k_e = kv && kc == 14;
    m_dstb = 0; m_mstb = 0;
    if (r || !card) begin
      session_clear();
      return;
    end
    case (m_ph)
      P_IDLE: begin m_ph = P_SELECT; m_recib = 1; end
      P_SELECT: begin
        if (k_a || k_b) begin m_tipo = k_b; pin_q.delete(); m_ph = P_PIN; end
        else if (k_c) m_ph = P_EJECT;
      end
      P_PIN: begin
        if (k_c) m_ph = P_EJECT;
        else if (is_dig) begin
          pin_q.push_back(kc); m_dig = kc; m_dstb = 1;
          if (pin_q.size() == N_PIN) begin m_ph = P_WAIT_PIN; m_since = 0; end
        end
      end
      P_WAIT_PIN: begin
        if (bl) m_ph = P_BLOCKED;
        else if (pi) begin pin_q.delete(); m_ph = P_PIN; end
        else if (k_c) m_ph = P_EJECT;
        else begin
          m_since++;
          if (m_since >= PIN_TIMEOUT) begin amt_q.delete(); m_ph = P_AMOUNT; end
        end
      end
      P_AMOUNT: begin
        if (k_c) m_ph = P_EJECT;
        else if (is_dig) begin
          if (amt_q.size() < MAX_DIGITOS) amt_q.push_back(kc);
        end else if (k_e && amt_q.size() > 0) begin
          m_mstb = 1; m_ph = P_WAIT_RES;
        end
      end
      P_WAIT_RES: if (res || k_c) m_ph = P_EJECT;
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      n_cmp++;
      if (tarjeta_recibida !== m_recib || tipo_trnans !== m_tipo || digito_stb !== m_dstb ||
          digito !== 4'(m_dig) || monto_stb !== m_mstb || monto !== 32'(amt_val()) ||
          estado !== 3'(m_ph)) begin
        n_err++;
        $display("FAIL outputs t=%0t got rec=%b tipo=%b dstb=%b dig=%0d mstb=%b monto=%0d est=%0d exp rec=%b tipo=%b dstb=%b dig=%0d mstb=%b monto=%0d est=%0d",
                 $time, tarjeta_recibida, tipo_trnans, digito_stb, digito, monto_stb, monto, estado,
                 m_recib, m_tipo, m_dstb, m_dig, m_mstb, amt_val(), m_ph);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit card, input bit kv, input int kc, input bit pi, input bit bl,
                       input bit ed, input bit fi, input bit ba, input bit r);
    @(negedge clk);
    rst = r; tarjeta_in = card; key_valid = kv; key_code = 4'(kc);
    pin_incorrecto = pi; bloqueo = bl;
    entregar_dinero = ed; fondos_insuficientes = fi; balance_actualizado = ba;
    model_adv(r, card, kv, kc, pi, bl, ed || fi || ba);
    cmp_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic key(input int kc);
    drive(1, 1, kc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic card_out();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic to_amount(input int sel);
    idle(1);
    key(sel);
    for (int d = 1; d <= N_PIN; d++) key(d);
    idle(PIN_TIMEOUT);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("reset_estado", estado, 0);
    check("reset_recibida", tarjeta_recibida, 0);
    check("reset_monto", monto, 0);

    idle(1);
    check("card_in_recibida", tarjeta_recibida, 1);
    check("card_in_estado", estado, 1);
    key(11);
    check("withdraw_tipo", tipo_trnans, 1);
    for (int d = 1; d <= 4; d++) begin
      key(d);
      check("pin_stb", digito_stb, 1);
      check("pin_digit", digito, d);
    end
    check("wait_pin_estado", estado, 3);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    check("pin_retry_estado", estado, 2);
    check("pin_retry_nostb", digito_stb, 0);
    for (int d = 5; d <= 8; d++) begin
      key(d);
      check("pin2_digit", digito, d);
    end
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    check("blocked_estado", estado, 7);
    key(3);
    check("blocked_nostb", digito_stb, 0);
    check("blocked_digit_hold", digito, 8);
    card_out();
    check("card_out_estado", estado, 0);
    check("card_out_tipo", tipo_trnans, 0);

    to_amount(10);
    check("amount_estado", estado, 4);
    key(5); key(0); key(0);
    check("amount_500_pre", monto, 500);
    check("amount_nostb", monto_stb, 0);
    key(14);
    check("amount_stb", monto_stb, 1);
    check("amount_500", monto, 500);
    idle(1);
    check("amount_stb_once", monto_stb, 0);
    check("amount_hold", monto, 500);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    check("entregar_eject", estado, 6);
    card_out();

    to_amount(10);
    repeat (10) key(9);
    check("amount_max", monto, 999_999_999);
    key(14);
    check("amount_max_stb", monto_stb, 1);
    card_out();

    to_amount(10);
    key(14);
    check("empty_e_nostb", monto_stb, 0);
    check("empty_e_estado", estado, 4);
    key(12);
    check("cancel_estado", estado, 6);
    check("cancel_nostb", monto_stb, 0);
    card_out();
    check("eject_out_estado", estado, 0);
    check("eject_out_recibida", tarjeta_recibida, 0);

    idle(1);
    key(11);
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0);
    check("race_nostb", digito_stb, 0);
    check("race_estado", estado, 0);

    to_amount(10);
    key(7); key(7);
    check("amount_77", monto, 77);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_monto", monto, 0);
    check("rst_estado", estado, 0);

    for (int i = 0; i < 3000; i++) begin
      int sel, kc;
      sel = $urandom_range(0, 99);
      if (sel < 60) kc = $urandom_range(0, 9);
      else if (sel < 72) kc = 10;
      else if (sel < 84) kc = 11;
      else if (sel < 88) kc = 12;
      else if (sel < 97) kc = 14;
      else kc = ($urandom_range(0, 1) == 0) ? 13 : 15;
      drive($urandom_range(0, 79) != 0, $urandom_range(0, 1) == 1, kc,
            $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 999) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
